blockmem_2p_rd_stream: RTL and testbench

//  Read-side sequencer for the two-port block memory wrapper (blockmem_2p_wrapper, read port B).
//  - Accepts a burst command (start address, length) and issues one read per cycle on port B.
//  - Captures read data after a fixed pipeline latency and streams it out as valid/ready beats with tlast.
//  - A credit-limited output FIFO absorbs in-flight reads under backpressure, so no beat is ever dropped.

---
 rtl/blockmem_2p_rd_stream.sv | 215 +++++++++++++++++++++
 tb/tb_blockmem_2p_rd_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockmem_2p_rd_stream.sv
// blockmem_2p_rd_stream
// Read-side burst sequencer for port B of the two-port block memory wrapper.
// A burst command (start address, beats-1) becomes one memory read per cycle.
// Each read is tagged through a shift register matching the memory latency, so
// its data can be captured into a small output FIFO. The FIFO drives an AXI-stream
// style valid/ready output. A credit rule (FIFO fill plus reads in flight) throttles
// issue so that backpressure never loses a beat.
module blockmem_2p_rd_stream #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    parameter int G_RDLATENCY = 1,
    parameter int G_LENWIDTH  = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [G_ADDRWIDTH-1:0] cmd_addr,
    input  logic [G_LENWIDTH-1:0]  cmd_len,
    output logic                   mem_en,
    output logic [G_ADDRWIDTH-1:0] mem_addr,
    input  logic [G_DATAWIDTH-1:0] mem_dout,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [G_DATAWIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    output logic                   busy
);

    localparam int C_FIFODEPTH = G_RDLATENCY + 2;
    localparam int C_CNTW      = $clog2(C_FIFODEPTH + 1);
    localparam int C_OCCW      = $clog2(2 * C_FIFODEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Next word address, wrapping at the end of a memory that need not be a power of two
    function automatic logic [G_ADDRWIDTH-1:0] addr_inc(input logic [G_ADDRWIDTH-1:0] a);
        logic [G_ADDRWIDTH-1:0] r;
        if (a == G_ADDRWIDTH'(G_MEMDEPTH - 1)) begin
            r = {G_ADDRWIDTH{1'b0}};
        end else begin
            r = a + G_ADDRWIDTH'(1);
        end
        return r;
    endfunction

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    busy_q;
    logic                    mem_en_q;
    logic [G_ADDRWIDTH-1:0]  mem_addr_q;
    logic [G_ADDRWIDTH-1:0]  addr_q;
    logic [G_LENWIDTH-1:0]   left_q;
    logic                    mem_last_q;
    logic [G_RDLATENCY-1:0]  tag_vld_q;
    logic [G_RDLATENCY-1:0]  tag_last_q;
    logic [G_DATAWIDTH-1:0]  fifo_data_q [C_FIFODEPTH];
    logic [C_FIFODEPTH-1:0]  fifo_last_q;
    logic [C_CNTW-1:0]       fifo_cnt_q;
    logic                    m_tvalid_q;

    logic [G_DATAWIDTH-1:0]  fifo_data_sh_s [C_FIFODEPTH];
    logic [C_FIFODEPTH-1:0]  fifo_last_sh_s;
    logic [G_DATAWIDTH-1:0]  fifo_data_d [C_FIFODEPTH];
    logic [C_FIFODEPTH-1:0]  fifo_last_d;
    logic [C_CNTW-1:0]       fifo_cnt_d;
    logic [C_CNTW-1:0]       wr_idx_s;
    logic [C_OCCW-1:0]       occ_s;
    logic                    credit_s;
    logic                    push_s;
    logic                    push_last_s;
    logic                    pop_s;
    logic                    tlast_hs_s;

    assign push_s      = tag_vld_q[G_RDLATENCY-1];
    assign push_last_s = tag_last_q[G_RDLATENCY-1];
    assign pop_s       = m_tvalid_q & m_tready;
    assign tlast_hs_s  = pop_s & fifo_last_q[0];

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tdata   = fifo_data_q[0];
    assign m_tlast   = fifo_last_q[0];

    // Credit: buffered beats plus reads not yet written, less the beat leaving this cycle
    always_comb begin
        occ_s = C_OCCW'(fifo_cnt_q) + C_OCCW'(mem_en_q);
        for (int i = 0; i < G_RDLATENCY; i++) begin
            occ_s = occ_s + C_OCCW'(tag_vld_q[i]);
        end
        credit_s = (occ_s - C_OCCW'(pop_s)) < C_OCCW'(C_FIFODEPTH);
    end

    // Shift-out FIFO next state: entry 0 is always the head, a push lands behind the last valid entry
    always_comb begin
        wr_idx_s   = fifo_cnt_q - C_CNTW'(pop_s);
        fifo_cnt_d = fifo_cnt_q + C_CNTW'(push_s) - C_CNTW'(pop_s);
        for (int i = 0; i < C_FIFODEPTH - 1; i++) begin
            fifo_data_sh_s[i] = pop_s ? fifo_data_q[i+1] : fifo_data_q[i];
            fifo_last_sh_s[i] = pop_s ? fifo_last_q[i+1] : fifo_last_q[i];
        end
        fifo_data_sh_s[C_FIFODEPTH-1] = fifo_data_q[C_FIFODEPTH-1];
        fifo_last_sh_s[C_FIFODEPTH-1] = fifo_last_q[C_FIFODEPTH-1];
        for (int i = 0; i < C_FIFODEPTH; i++) begin
            if (push_s && (wr_idx_s == C_CNTW'(i))) begin
                fifo_data_d[i] = mem_dout;
                fifo_last_d[i] = push_last_s;
            end else begin
                fifo_data_d[i] = fifo_data_sh_s[i];
                fifo_last_d[i] = fifo_last_sh_s[i];
            end
        end
    end

    // Command / issue FSM with registered handshake and memory outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= {G_ADDRWIDTH{1'b0}};
            addr_q      <= {G_ADDRWIDTH{1'b0}};
            left_q      <= {G_LENWIDTH{1'b0}};
            mem_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        // First read goes out in the cycle right after the handshake
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= cmd_addr;
                        addr_q      <= addr_inc(cmd_addr);
                        left_q      <= cmd_len;
                        mem_last_q  <= (cmd_len == {G_LENWIDTH{1'b0}});
                        state_q     <= (cmd_len == {G_LENWIDTH{1'b0}}) ? S_DRAIN : S_ISSUE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                        mem_en_q    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (credit_s) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        addr_q     <= addr_inc(addr_q);
                        left_q     <= left_q - G_LENWIDTH'(1);
                        mem_last_q <= (left_q == G_LENWIDTH'(1));
                        state_q    <= (left_q == G_LENWIDTH'(1)) ? S_DRAIN : S_ISSUE;
                    end else begin
                        mem_en_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    mem_en_q <= 1'b0;
                    if (tlast_hs_s) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    mem_en_q    <= 1'b0;
                end
            endcase
        end
    end

    // Read tags track each issued read until its data appears on mem_dout, then the FIFO captures it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_vld_q  <= {G_RDLATENCY{1'b0}};
            tag_last_q <= {G_RDLATENCY{1'b0}};
            fifo_cnt_q <= {C_CNTW{1'b0}};
            fifo_last_q <= {C_FIFODEPTH{1'b0}};
            m_tvalid_q <= 1'b0;
            for (int i = 0; i < C_FIFODEPTH; i++) begin
                fifo_data_q[i] <= {G_DATAWIDTH{1'b0}};
            end
        end else begin
            tag_vld_q[0]  <= mem_en_q;
            tag_last_q[0] <= mem_en_q & mem_last_q;
            for (int i = 1; i < G_RDLATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_last_q <= fifo_last_d;
            m_tvalid_q  <= (fifo_cnt_d != {C_CNTW{1'b0}});
            for (int i = 0; i < C_FIFODEPTH; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
            end
        end
    end

    // The credit rule must keep every push within the FIFO
    a_no_overflow : assert property (@(posedge aclk) disable iff (!aresetn)
        !(push_s && !pop_s && (fifo_cnt_q == C_CNTW'(C_FIFODEPTH))));

endmodule

// File: tb/tb_blockmem_2p_rd_stream.sv
// Bench for blockmem_2p_rd_stream: memory model with configurable latency,
// reference beat queue derived from each accepted command, negedge monitor.
module tb_blockmem_2p_rd_stream;

    localparam int P_DW    = 32;
    localparam int P_MD    = 1000;
    localparam int P_AW    = $clog2(P_MD);
    localparam int P_RDLAT = 2;
    localparam int P_LW    = 8;
    localparam int P_FD    = P_RDLAT + 2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [P_AW-1:0] cmd_addr;
    logic [P_LW-1:0] cmd_len;
    logic            mem_en;
    logic [P_AW-1:0] mem_addr;
    logic [P_DW-1:0] mem_dout;
    logic            m_tvalid;
    logic            m_tready;
    logic [P_DW-1:0] m_tdata;
    logic            m_tlast;
    logic            busy;

    always #5 aclk = ~aclk;

    blockmem_2p_rd_stream #(
        .G_DATAWIDTH(P_DW), .G_MEMDEPTH(P_MD), .G_ADDRWIDTH(P_AW),
        .G_RDLATENCY(P_RDLAT), .G_LENWIDTH(P_LW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .busy(busy)
    );

    logic [P_DW-1:0] mem [P_MD];
    logic [P_DW-1:0] rd_pipe [P_RDLAT];
    assign mem_dout = rd_pipe[P_RDLAT-1];

    int n_cmp = 0;
    int n_err = 0;
    logic [P_DW:0]   exp_q[$];
    logic [P_AW-1:0] issue_q[$];
    int issued_n;
    int popped_n;
    int t4_exp[4] = '{998, 999, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Memory: registered read with P_RDLAT total cycles from enable to data
    initial begin
        for (int k = 0; k < P_RDLAT; k++) rd_pipe[k] = '0;
        forever begin
            @(posedge aclk);
            for (int k = P_RDLAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
            if (mem_en) rd_pipe[0] <= mem[mem_addr];
        end
    end

    // Monitor: address range, credit bound, AXI hold, and beat-by-beat comparison
    initial begin
        logic [P_DW:0] e;
        logic [P_DW:0] held;
        bit hold_chk;
        held = '0;
        hold_chk = 1'b0;
        issued_n = 0;
        popped_n = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                issued_n = 0;
                popped_n = 0;
                hold_chk = 1'b0;
            end else begin
                if (mem_en) begin
                    issued_n++;
                    issue_q.push_back(mem_addr);
                    chk("addr_range", (int'(mem_addr) < P_MD), 1);
                    chk("credit_limit", ((issued_n - popped_n) <= P_FD), 1);
                end
                if (hold_chk) begin
                    chk("hold_valid", m_tvalid, 1);
                    chk("hold_beat", {m_tlast, m_tdata}, held);
                end
                if (m_tvalid && m_tready) begin
                    popped_n++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {m_tlast, m_tdata}, e);
                    end
                end
                hold_chk = m_tvalid && !m_tready;
                held = {m_tlast, m_tdata};
            end
        end
    end

    task automatic send_cmd(input int addr, input int len);
        bit acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr = P_AW'(addr);
        cmd_len = P_LW'(len);
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", acc, 1);
        if (acc) begin
            for (int i = 0; i <= len; i++) exp_q.push_back({(i == len), mem[(addr + i) % P_MD]});
        end
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (!busy) begin
                done = 1'b1;
            end else begin
                m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                tick();
            end
        end
        m_tready = 1'b1;
        chk("idle_reached", done, 1);
        chk("all_beats_seen", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tdata"}, m_tdata, 0);
        chk({tag, "_m_tlast"}, m_tlast, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit acc;
        bit prev;
        bit got;
        int base;
        aresetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        m_tready = 1'b0;
        for (int i = 0; i < P_MD; i++) mem[i] = $urandom;

        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outputs("rst");
        aresetn = 1'b1;
        tick();
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_busy", busy, 0);

        // 1: single beat at address 5, exact latency and busy drop
        m_tready = 1'b1;
        send_cmd(5, 0);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_addr", mem_addr, 5);
        chk("t1_busy", busy, 1);
        chk("t1_cmd_ready", cmd_ready, 0);
        repeat (P_RDLAT) begin
            chk("t1_no_valid_yet", m_tvalid, 0);
            tick();
            chk("t1_single_issue", mem_en, 0);
        end
        chk("t1_no_valid_yet", m_tvalid, 0);
        tick();
        chk("t1_valid", m_tvalid, 1);
        chk("t1_tlast", m_tlast, 1);
        chk("t1_data", m_tdata, mem[5]);
        chk("t1_busy_hold", busy, 1);
        tick();
        chk("t1_busy_fall", busy, 0);
        chk("t1_cmd_ready_back", cmd_ready, 1);
        chk("t1_valid_fall", m_tvalid, 0);
        wait_idle(0);

        // 2: eight back-to-back beats at full throughput
        send_cmd(0, 7);
        repeat (P_RDLAT + 1) tick();
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", m_tvalid, 1);
            chk("t2_last", m_tlast, (i == 7));
            tick();
        end
        wait_idle(0);

        // 3: toggling then stalled ready, issue must stop at the credit limit
        send_cmd($urandom_range(0, P_MD - 1), 15);
        for (int i = 0; i < 8; i++) begin
            m_tready = (i % 2 == 1);
            tick();
        end
        m_tready = 1'b0;
        repeat (10) tick();
        chk("t3_occupancy_full", issued_n - popped_n, P_FD);
        chk("t3_mem_en_stalled", mem_en, 0);
        chk("t3_valid_held", m_tvalid, 1);
        wait_idle(0);

        // 4: address wrap on a non power-of-two memory
        issue_q.delete();
        send_cmd(998, 3);
        wait_idle(0);
        chk("t4_issue_count", issue_q.size(), 4);
        if (issue_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t4_addr", issue_q[k], t4_exp[k]);
        end

        // 5: reset during beat 3 of 8, then a fresh two-beat burst
        m_tready = 1'b1;
        base = popped_n;
        send_cmd($urandom_range(0, P_MD - 1), 7);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (popped_n - base == 2 && m_tvalid) got = 1'b1;
            else tick();
        end
        chk("t5_reached_beat3", got, 1);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t5_rst");
        exp_q.delete();
        tick();
        tick();
        chk("t5_valid_in_rst", m_tvalid, 0);
        aresetn = 1'b1;
        tick();
        chk("t5_cmd_ready", cmd_ready, 1);
        send_cmd($urandom_range(0, P_MD - 1), 1);
        wait_idle(0);
        repeat (6) tick();
        chk("t5_beat_count", popped_n, 2);
        chk("t5_quiet", m_tvalid, 0);

        // 6: second command held valid must wait for the first tlast handshake
        send_cmd(10, 3);
        cmd_valid = 1'b1;
        cmd_addr = P_AW'(20);
        cmd_len = P_LW'(2);
        acc = 1'b0;
        prev = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (cmd_ready) begin
                acc = 1'b1;
                chk("t6_accept_after_tlast", prev, 1);
            end
            prev = m_tvalid && m_tready && m_tlast;
            tick();
        end
        cmd_valid = 1'b0;
        chk("t6_accept", acc, 1);
        if (acc) begin
            for (int i = 0; i <= 2; i++) exp_q.push_back({(i == 2), mem[20 + i]});
        end
        wait_idle(0);

        // Random bursts under random backpressure, then the maximum length burst
        for (int r = 0; r < 8; r++) begin
            send_cmd($urandom_range(0, P_MD - 1), $urandom_range(0, 40));
            wait_idle(1);
        end
        send_cmd($urandom_range(0, P_MD - 1), 255);
        wait_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
